mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_pick2.sv | 23 ++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and FSM encoding for the I/D memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  // Requester identifiers, also used as the last-served flag value.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP   = 3'd3,
    HOLD   = 3'd4
  } arb_state_e;

  // Map a requester ID onto the busy state that serves it.
  function automatic arb_state_e busyStateFor(input logic id);
    return (id == REQ_D) ? BUSY_D : BUSY_I;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick between the I-cache and D-cache requesters.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic reqI_i,
  input  logic reqD_i,
  input  logic lastServed_i,
  output logic grantId_o,
  output logic valid_o
);

  // A lone requester always wins; on a tie the side not served last wins.
  always_comb begin
    valid_o   = reqI_i | reqD_i;
    grantId_o = REQ_I;
    if (reqI_i && reqD_i) begin
      grantId_o = ~lastServed_i;
    end else if (reqD_i) begin
      grantId_o = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache and D-cache, one block transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e        state_q, state_d;
  logic              grantId_q, grantId_d;
  logic              opWrite_q, opWrite_d;
  logic              lastServed_q, lastServed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pickValid, pickId, busy;

  rr_pick2 u_pick (
    .reqI_i      (i_mem_read | i_mem_write),
    .reqD_i      (d_mem_read | d_mem_write),
    .lastServed_i(lastServed_q),
    .grantId_o   (pickId),
    .valid_o     (pickValid)
  );

  // State and transaction registers; reset abandons any transaction immediately.
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q      <= IDLE;
      grantId_q    <= REQ_I;
      opWrite_q    <= 1'b0;
      lastServed_q <= REQ_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grantId_q    <= grantId_d;
      opWrite_q    <= opWrite_d;
      lastServed_q <= lastServed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Latch the winner in IDLE, wait on memory while busy, pulse ready in RESP, settle in HOLD.
  always_comb begin
    state_d      = state_q;
    grantId_d    = grantId_q;
    opWrite_d    = opWrite_q;
    lastServed_d = lastServed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          grantId_d = pickId;
          if (pickId == REQ_D) begin
            opWrite_d = d_mem_write;
            addr_d    = d_mem_addr;
            wdata_d   = d_mem_wdata;
          end else begin
            opWrite_d = i_mem_write;
            addr_d    = i_mem_addr;
            wdata_d   = i_mem_wdata;
          end
          state_d = busyStateFor(pickId);
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          if (!opWrite_q) begin
            rdata_d = mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = HOLD;
      end
      HOLD: begin
        lastServed_d = grantId_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come straight from registers so strobes are exclusive and stable while busy.
  always_comb begin
    busy        = (state_q == BUSY_I) || (state_q == BUSY_D);
    mem_read    = busy && !opWrite_q;
    mem_write   = busy && opWrite_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    i_mem_ready = (state_q == RESP) && (grantId_q == REQ_I);
    d_mem_ready = (state_q == RESP) && (grantId_q == REQ_D);
    i_mem_rdata = rdata_q;
    d_mem_rdata = rdata_q;
  end

endmodule
